// File: rtl/trade_order_gen_pkg.sv
// Shared types and constants for the trade order generator.
package trade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        COOLDOWN
    } order_state_t;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;
    localparam int   POS_W     = 9;

    // Order size is the nominal quantity, trimmed to whatever headroom is left.
    function automatic logic [7:0] clip_qty(input logic signed [9:0] headroom,
                                            input logic [7:0]        qty);
        logic signed [9:0] qty_ext;
        qty_ext = $signed({2'b00, qty});
        return (headroom < qty_ext) ? headroom[7:0] : qty;
    endfunction

endpackage

// File: rtl/trade_order_gen_if.sv
// Order port bundle between the generator (master) and the downstream consumer (slave).
interface trade_order_gen_if;
    // An order transfers at a posedge where order_valid && order_ready. Once valid
    // rises, side/qty/price are frozen and valid stays high until that transfer;
    // ready may be high at any time and never gates the rise of valid.
    logic       order_valid;
    logic       order_ready;
    logic       order_side;
    logic [7:0] order_qty;
    logic [7:0] order_price;

    modport master (
        output order_valid,
        output order_side,
        output order_qty,
        output order_price,
        input  order_ready
    );

    modport slave (
        input  order_valid,
        input  order_side,
        input  order_qty,
        input  order_price,
        output order_ready
    );
endinterface

// File: rtl/trade_order_gen_cooldown_ctr.sv
// Load/decrement counter timing the post-order cooldown; done marks the last cycle.
module trade_cooldown_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       done_o
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= 4'd1);
endmodule

// File: rtl/trade_order_gen.sv
// Position-limited order generator with valid/ready order port and post-order cooldown.
// Macro TRADE_DROP_CNT_EN adds a saturating drop_count output.
module trade_order_gen
    import trade_pkg::*;
#(
    parameter logic [7:0] QTY      = 8'd10,
    parameter logic [7:0] MAX_POS  = 8'd50,
    parameter logic [3:0] COOLDOWN = 4'd8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    buy_signal,
    input  logic                    sell_signal,
    input  logic [7:0]              price,
    trade_order_gen_if.master       ord,
    output logic signed [POS_W-1:0] position,
    output logic                    busy,
`ifdef TRADE_DROP_CNT_EN
    output logic [15:0]             drop_count,
`endif
    output order_state_t            dbg_state_o
);
    localparam logic signed [9:0] MAX_EXT = $signed({2'b00, MAX_POS});

    order_state_t            state_q, state_d;
    logic                    side_q, side_d;
    logic [7:0]              qty_q, qty_d;
    logic [7:0]              price_q, price_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic signed [9:0]       pos_ext, headroom;
    logic                    cd_load, cd_done, drop;

    trade_cooldown_ctr u_cooldown (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cd_load),
        .load_val_i (COOLDOWN),
        .done_o     (cd_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            side_q  <= 1'b0;
            qty_q   <= 8'd0;
            price_q <= 8'd0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            qty_q   <= qty_d;
            price_q <= price_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        side_d   = side_q;
        qty_d    = qty_q;
        price_d  = price_q;
        pos_d    = pos_q;
        cd_load  = 1'b0;
        drop     = 1'b0;
        pos_ext  = {pos_q[POS_W-1], pos_q};
        headroom = buy_signal ? (MAX_EXT - pos_ext) : (MAX_EXT + pos_ext);

        case (state_q)
            IDLE: begin
                if (buy_signal && sell_signal) begin
                    drop = 1'b1;
                end else if (buy_signal || sell_signal) begin
                    if (headroom == 10'sd0) begin
                        drop = 1'b1;
                    end else begin
                        side_d  = buy_signal ? SIDE_BUY : SIDE_SELL;
                        price_d = price;
                        qty_d   = clip_qty(headroom, QTY);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (ord.order_ready) begin
                    pos_d = (side_q == SIDE_BUY) ? pos_q + $signed({1'b0, qty_q})
                                                 : pos_q - $signed({1'b0, qty_q});
                    if (COOLDOWN == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = trade_pkg::COOLDOWN;
                        cd_load = 1'b1;
                    end
                end
            end
            trade_pkg::COOLDOWN: begin
                if (cd_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ord.order_valid = (state_q == SEND);
    assign ord.order_side  = side_q;
    assign ord.order_qty   = qty_q;
    assign ord.order_price = price_q;
    assign position        = pos_q;
    assign busy            = (state_q != IDLE);
    assign dbg_state_o     = state_q;

`ifdef TRADE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop;
`endif
endmodule

// File: tb/tb_trade_order_gen.sv
// Bench for trade_order_gen: two instances (default, and MAX_POS=55 / COOLDOWN=0) against a cycle-budget model.
module tb_trade_order_gen;
    import trade_pkg::*;

    localparam int W     = 17;
    localparam int P_QTY = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              buy_signal, sell_signal;
    logic [7:0]        price;
    logic signed [8:0] pos_a, pos_b;
    logic              busy_a, busy_b;
    order_state_t      dbg_a, dbg_b;
`ifdef TRADE_DROP_CNT_EN
    logic [15:0]       drops_a, drops_b;
`endif

    trade_order_gen_if ord_a ();
    trade_order_gen_if ord_b ();

    trade_order_gen u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .buy_signal  (buy_signal),
        .sell_signal (sell_signal),
        .price       (price),
        .ord         (ord_a),
        .position    (pos_a),
        .busy        (busy_a),
`ifdef TRADE_DROP_CNT_EN
        .drop_count  (drops_a),
`endif
        .dbg_state_o (dbg_a)
    );

    trade_order_gen #(.QTY(8'd10), .MAX_POS(8'd55), .COOLDOWN(4'd0)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .buy_signal  (buy_signal),
        .sell_signal (sell_signal),
        .price       (price),
        .ord         (ord_b),
        .position    (pos_b),
        .busy        (busy_b),
`ifdef TRADE_DROP_CNT_EN
        .drop_count  (drops_b),
`endif
        .dbg_state_o (dbg_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model: orders as records, the busy window as an edge-count budget.
    function automatic int p_max(input int i);
        return (i == 0) ? 50 : 55;
    endfunction

    function automatic int p_cd(input int i);
        return (i == 0) ? 8 : 0;
    endfunction

    int         cyc = 0;
    int         m_pos[2], m_free[2], m_drops[2];
    bit         m_pend[2], m_side[2], m_busy[2];
    logic [7:0] m_qty[2], m_price[2];
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    task automatic model_edge(input logic b, input logic s, input logic [7:0] p,
                              input logic r, input logic rs);
        int head;
        for (int i = 0; i < 2; i++) begin
            if (!rs) begin
                m_pos[i] = 0; m_free[i] = 0; m_drops[i] = 0;
                m_pend[i] = 0; m_side[i] = 0; m_qty[i] = 0; m_price[i] = 0;
            end else if (m_pend[i]) begin
                if (r) begin
                    m_pos[i]  = m_side[i] ? m_pos[i] + int'(m_qty[i]) : m_pos[i] - int'(m_qty[i]);
                    m_pend[i] = 0;
                    m_free[i] = cyc + p_cd(i) + 1;
                end
            end else if (cyc >= m_free[i]) begin
                head = b ? p_max(i) - m_pos[i] : p_max(i) + m_pos[i];
                if ((b && s) || ((b || s) && head == 0)) begin
                    if (m_drops[i] < 65535) m_drops[i]++;
                end else if (b || s) begin
                    m_side[i]  = b;
                    m_qty[i]   = 8'((head < P_QTY) ? head : P_QTY);
                    m_price[i] = p;
                    m_pend[i]  = 1;
                    if (i == 0) exp_q_a.push_back({m_side[i], m_qty[i], m_price[i]});
                    else        exp_q_b.push_back({m_side[i], m_qty[i], m_price[i]});
                end
            end
            m_busy[i] = m_pend[i] || (cyc + 1 < m_free[i]);
        end
        if (!rs) begin
            exp_q_a.delete();
            exp_q_b.delete();
        end
        cyc++;
    endtask

    task automatic sb_pop(input int i, input logic [W-1:0] obs);
        logic [W-1:0] exp;
        if (i == 0 && exp_q_a.size() == 0 || i == 1 && exp_q_b.size() == 0) begin
            check_eq($sformatf("sb_extra[%0d]", i), 32'(1), 32'(0));
        end else begin
            exp = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            check_eq($sformatf("sb_order[%0d]", i), 32'(obs), 32'(exp));
        end
    endtask

    task automatic check_dut(input int i, input logic v, input logic sd, input logic [7:0] q,
                             input logic [7:0] pr, input logic signed [8:0] ps, input logic bz);
        check_eq($sformatf("valid[%0d]", i), 32'(v),  32'(m_pend[i]));
        check_eq($sformatf("side[%0d]", i),  32'(sd), 32'(m_side[i]));
        check_eq($sformatf("qty[%0d]", i),   32'(q),  32'(m_qty[i]));
        check_eq($sformatf("price[%0d]", i), 32'(pr), 32'(m_price[i]));
        check_eq($sformatf("pos[%0d]", i),   int'(ps), m_pos[i]);
        check_eq($sformatf("busy[%0d]", i),  32'(bz), 32'(m_busy[i]));
    endtask

    task automatic cycle(input logic b, input logic s, input logic [7:0] p, input logic r);
        buy_signal        = b;
        sell_signal       = s;
        price             = p;
        ord_a.order_ready = r;
        ord_b.order_ready = r;
        #1;
        if (rst_n && r && ord_a.order_valid === 1'b1)
            sb_pop(0, {ord_a.order_side, ord_a.order_qty, ord_a.order_price});
        if (rst_n && r && ord_b.order_valid === 1'b1)
            sb_pop(1, {ord_b.order_side, ord_b.order_qty, ord_b.order_price});
        @(posedge clk);
        model_edge(b, s, p, r, rst_n);
        @(negedge clk);
        check_dut(0, ord_a.order_valid, ord_a.order_side, ord_a.order_qty, ord_a.order_price, pos_a, busy_a);
        check_dut(1, ord_b.order_valid, ord_b.order_side, ord_b.order_qty, ord_b.order_price, pos_b, busy_b);
`ifdef TRADE_DROP_CNT_EN
        check_eq("drops[0]", 32'(drops_a), m_drops[0]);
        check_eq("drops[1]", 32'(drops_b), m_drops[1]);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_eq("rst_state_a", 32'(dbg_a), 32'(IDLE));
        check_eq("rst_state_b", 32'(dbg_b), 32'(IDLE));

        // Single buy at price 100, ready already high.
        cycle(1'b1, 1'b0, 8'd100, 1'b1);
        check_eq("t1_valid_a", 32'(ord_a.order_valid), 32'(1));
        check_eq("t1_qty_a",   32'(ord_a.order_qty),   32'(10));
        repeat (12) cycle(1'b0, 1'b0, 8'd0, 1'b1);
        check_eq("t1_pos_a", int'(pos_a), 10);

        // Held buy runs into the position limit; instance b ends on a partial order.
        do_reset();
        repeat (70) cycle(1'b1, 1'b0, 8'd42, 1'b1);
        check_eq("lim_pos_a", int'(pos_a), 50);
        check_eq("lim_pos_b", int'(pos_b), 55);
        check_eq("lim_qty_b", 32'(ord_b.order_qty), 32'(5));

        // Conflicting request.
        cycle(1'b1, 1'b1, 8'd77, 1'b1);
        check_eq("conf_valid_a", 32'(ord_a.order_valid), 32'(0));
        check_eq("conf_pos_a",   int'(pos_a), 50);

        // Sell held off by ready low for 6 cycles.
        cycle(1'b0, 1'b1, 8'd33, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 8'd0, 1'b0);
        check_eq("hold_valid_a", 32'(ord_a.order_valid), 32'(1));
        check_eq("hold_price_a", 32'(ord_a.order_price), 32'(33));
        check_eq("hold_side_a",  32'(ord_a.order_side),  32'(SIDE_SELL));
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 8'd0, 1'b1);
        check_eq("hold_pos_a", int'(pos_a), 40);
        check_eq("hold_pos_b", int'(pos_b), 45);

        // Reset while an order waits at position 20.
        do_reset();
        repeat (2) begin
            cycle(1'b1, 1'b0, 8'd50, 1'b1);
            repeat (10) cycle(1'b0, 1'b0, 8'd0, 1'b1);
        end
        check_eq("mid_pos_a", int'(pos_a), 20);
        cycle(1'b1, 1'b0, 8'd60, 1'b0);
        cycle(1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        check_eq("mid_rst_valid_a", 32'(ord_a.order_valid), 32'(0));
        check_eq("mid_rst_pos_a",   int'(pos_a), 0);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 8'd0, 1'b1);

        // Random traffic with occasional resets.
        repeat (400) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1;
        repeat (12) cycle(1'b0, 1'b0, 8'd0, 1'b1);

        check_eq("sb_left_a", 32'(exp_q_a.size()), 32'(0));
        check_eq("sb_left_b", 32'(exp_q_b.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
